ysyx_23060240_rd_arbiter: RTL and testbench
===========================================

Name: ysyx_23060240_rd_arbiter

Overview:
- Shares one AXI read port (address and data channels) between two requesters: IFU (instruction fetch) and LSU (load path).
- Sits between the core masters and the downstream read slave (CLINT/memory crossbar).
- Single-beat reads only; one transaction outstanding.
- LSU-priority scheme with an anti-starvation streak counter for the IFU.
- The LSU write channel does not pass through this block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
MAX_LSU_STREAK, 4, max consecutive contested LSU grants before the IFU is forced through (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ifu_araddr  in  ADDR_W  IFU read address
ifu_arvalid  in  1  IFU address valid
ifu_arready  out  1  IFU address accepted
ifu_rdata  out  DATA_W  IFU read data
ifu_rresp  out  2  IFU read response
ifu_rvalid  out  1  IFU data valid
ifu_rready  in  1  IFU data ready
lsu_araddr  in  ADDR_W  LSU read address
lsu_arvalid  in  1  LSU address valid
lsu_arready  out  1  LSU address accepted
lsu_rdata  out  DATA_W  LSU read data
lsu_rresp  out  2  LSU read response
lsu_rvalid  out  1  LSU data valid
lsu_rready  in  1  LSU data ready
m_araddr  out  ADDR_W  slave address (registered)
m_arvalid  out  1  slave address valid (registered)
m_arready  in  1  slave address ready
m_rdata  in  DATA_W  slave data
m_rresp  in  2  slave response
m_rvalid  in  1  slave data valid
m_rready  out  1  slave data ready

Behaviour:
- States: IDLE, ADDR, DATA. The owner register (IFU/LSU) is valid in ADDR and DATA.
- IDLE, arbitration (combinational):
  - Only one arvalid high: that master wins.
  - Both high: LSU wins unless streak == MAX_LSU_STREAK, in which case IFU wins.
  - The winner's arready is 1 in IDLE. The loser's arready is 0.
- IDLE, on the winner's arvalid && arready:
  - Latch the address into m_araddr and set owner.
  - Next state is ADDR, with m_arvalid = 1 from the next cycle.
- ADDR:
  - Both master arready = 0.
  - m_arvalid and m_araddr are held stable until m_arready.
  - On m_arvalid && m_arready: m_arvalid <= 0, next state is DATA.
- DATA:
  - owner_rvalid = m_rvalid; owner rdata/rresp = m_rdata/m_rresp; m_rready = owner_rready.
  - Non-owner rvalid = 0 and rdata = 0.
  - On m_rvalid && m_rready: next state is IDLE.
- Outside DATA: m_rready = 0, both rvalid = 0, both rdata = 0.
- Latency:
  - Master handshake at cycle N gives m_arvalid at N+1.
  - The r beat is forwarded combinationally in the same cycle as m_rvalid.
  - Minimum turnaround is 3 cycles per read plus slave latency.
- Back-to-back reads: the cycle of the r handshake never accepts a new address. There is always one IDLE cycle between transactions.
- Streak counter, updated only on IDLE accept:
  - LSU accepted while ifu_arvalid = 1: streak <= streak+1, saturating at MAX_LSU_STREAK.
  - IFU accepted, or LSU accepted with ifu_arvalid = 0: streak <= 0.
- rresp (OKAY/SLVERR/DECERR) passes through unmodified. The arbiter does not retry.
- A master dropping arvalid before its handshake is legal. Arbitration re-evaluates each IDLE cycle.
- Async reset, effective immediately:
  - Values: state = IDLE, m_arvalid = 0, m_araddr = 0, owner = IFU, streak = 0.
  - All ready/valid outputs are 0 whenever rst = 1.
- Reset mid-transaction drops the transaction. The downstream slave shares the same rst.

Decomposition:
- Shared package:
  - State encoding localparams (IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2).
  - Owner encoding (OWN_IFU = 1'b0, OWN_LSU = 1'b1).
  - AXI resp constants (OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11).
- One sub-module, ysyx_23060240_arb_pick: combinational winner selection from the two arvalids plus the streak, together with the saturating streak counter.

Test Plan:
- IFU only reads 0x8000_0000, slave returns 0xDEAD_BEEF after 2 cycles -> m_arvalid 1 cycle after handshake, ifu_rdata = 0xDEAD_BEEF, lsu_rvalid stays 0.
- Both arvalid held continuously, MAX_LSU_STREAK = 4 -> grant order LSU, LSU, LSU, LSU, IFU, LSU..., with streak visible 1..4 then 0.
- Slave stalls m_arready for 5 cycles -> m_araddr stable, both master arready = 0 throughout.
- Owner holds rready = 0 for 3 cycles while m_rvalid = 1 -> m_rready = 0, data held, completion only on rready.
- Slave returns rresp = 2'b11 on an LSU read of 0xa000_0050 -> lsu_rresp = 2'b11, next read arbitrated normally.
- rst asserted asynchronously mid-DATA -> outputs 0 immediately, state IDLE. After release, a new IFU read completes correctly.

Source files
------------

// File: rtl/ysyx_23060240_rd_arbiter_pkg.sv
// rtl/ysyx_23060240_rd_arbiter_pkg.sv - shared encodings for the IFU/LSU read arbiter
package ysyx_23060240_rd_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADDR = ST_ADDR,
    S_DATA = ST_DATA
  } state_e;

  // Which requester owns the transaction in flight
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // AXI read responses; forwarded untouched, OKAY doubles as the idle value
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bits needed to hold a streak count of 0..max_streak
  function automatic int streak_width(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/ysyx_23060240_arb_pick.sv
// rtl/ysyx_23060240_arb_pick.sv - LSU-priority winner select with IFU anti-starvation streak
module ysyx_23060240_arb_pick
  import ysyx_23060240_rd_arbiter_pkg::*;
#(
  parameter int MAX_LSU_STREAK = 4,
  parameter int STREAK_W       = streak_width(MAX_LSU_STREAK)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ifu_arvalid_i,
  input  logic lsu_arvalid_i,
  input  logic accept_i,
  output logic grant_ifu_o,
  output logic grant_lsu_o
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                ifu_forced;

  // Once the LSU has won MAX_LSU_STREAK contested rounds, the IFU gets the next one
  assign ifu_forced  = ifu_arvalid_i && lsu_arvalid_i && (streak_q == STREAK_MAX);
  assign grant_lsu_o = lsu_arvalid_i && !ifu_forced;
  assign grant_ifu_o = ifu_arvalid_i && !grant_lsu_o;

  // Streak only moves on an accepted address; uncontested LSU wins clear it
  always_comb begin
    streak_d = streak_q;
    if (accept_i) begin
      if (grant_lsu_o && ifu_arvalid_i) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  // Streak register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/ysyx_23060240_rd_arbiter.sv
// rtl/ysyx_23060240_rd_arbiter.sv - shares one single-beat AXI read port between IFU and LSU
module ysyx_23060240_rd_arbiter
  import ysyx_23060240_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  state_e            state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] m_araddr_q;
  logic              m_arvalid_q;

  logic grant_ifu;
  logic grant_lsu;
  logic in_idle;
  logic in_data;
  logic accept;

  // rst gates the combinational side so every ready/valid drops the instant it rises
  assign in_idle = (state_q == S_IDLE) && !rst;
  assign in_data = (state_q == S_DATA) && !rst;

  // The winner's arready is 1 in IDLE, so any winner means a handshake this cycle
  assign accept = in_idle && (grant_ifu || grant_lsu);

  ysyx_23060240_arb_pick #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK)
  ) u_pick (
    .clk_i         (clk),
    .rst_i         (rst),
    .ifu_arvalid_i (ifu_arvalid),
    .lsu_arvalid_i (lsu_arvalid),
    .accept_i      (accept),
    .grant_ifu_o   (grant_ifu),
    .grant_lsu_o   (grant_lsu)
  );

  assign ifu_arready = in_idle && grant_ifu;
  assign lsu_arready = in_idle && grant_lsu;
  assign m_araddr    = m_araddr_q;
  assign m_arvalid   = m_arvalid_q;

  // Transaction FSM: latch winner address, present it downstream, wait for the r beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IFU;
      m_araddr_q  <= '0;
      m_arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            owner_q     <= grant_lsu ? OWN_LSU : OWN_IFU;
            m_araddr_q  <= grant_lsu ? lsu_araddr : ifu_araddr;
            m_arvalid_q <= 1'b1;
            state_q     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_arvalid_q && m_arready) begin
            m_arvalid_q <= 1'b0;
            state_q     <= S_DATA;
          end
        end
        S_DATA: begin
          // Always return to IDLE: a new address is never taken in the r-handshake cycle
          if (m_rvalid && m_rready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          m_arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Route the r channel to the owner only during DATA; everything else reads as zero
  always_comb begin
    m_rready   = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    ifu_rresp  = RESP_OKAY;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    lsu_rresp  = RESP_OKAY;
    if (in_data) begin
      if (owner_q == OWN_LSU) begin
        m_rready   = lsu_rready;
        lsu_rvalid = m_rvalid;
        lsu_rdata  = m_rdata;
        lsu_rresp  = m_rresp;
      end else begin
        m_rready   = ifu_rready;
        ifu_rvalid = m_rvalid;
        ifu_rdata  = m_rdata;
        ifu_rresp  = m_rresp;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_rd_arbiter.sv
// tb/tb_ysyx_23060240_rd_arbiter.sv - directed vector bench for the IFU/LSU read arbiter
module tb_ysyx_23060240_rd_arbiter;
  import ysyx_23060240_rd_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ifu_araddr, lsu_araddr, m_araddr;
  logic        ifu_arvalid, ifu_arready, lsu_arvalid, lsu_arready;
  logic [31:0] ifu_rdata, lsu_rdata, m_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, m_rresp;
  logic        ifu_rvalid, ifu_rready, lsu_rvalid, lsu_rready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_23060240_rd_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_rdata   (ifu_rdata),
    .ifu_rresp   (ifu_rresp),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rready  (ifu_rready),
    .lsu_araddr  (lsu_araddr),
    .lsu_arvalid (lsu_arvalid),
    .lsu_arready (lsu_arready),
    .lsu_rdata   (lsu_rdata),
    .lsu_rresp   (lsu_rresp),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rready  (lsu_rready),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready)
  );

  typedef struct packed {
    logic        ifu_v;
    logic [31:0] ifu_a;
    logic        ifu_rr;
    logic        lsu_v;
    logic [31:0] lsu_a;
    logic        lsu_rr;
    logic        m_ar;
    logic        m_rv;
    logic [31:0] m_rd;
    logic [1:0]  m_rs;
  } in_t;

  typedef struct packed {
    logic        ifu_arready;
    logic        lsu_arready;
    logic        m_arvalid;
    logic [31:0] m_araddr;
    logic        m_rready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];

  localparam logic        N  = 1'b0;
  localparam logic        Y  = 1'b1;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [1:0]  R0 = 2'b00;
  localparam logic [1:0]  R2 = 2'b10;
  localparam logic [1:0]  R3 = 2'b11;

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    ifu_arvalid = i.ifu_v;  ifu_araddr = i.ifu_a;  ifu_rready = i.ifu_rr;
    lsu_arvalid = i.lsu_v;  lsu_araddr = i.lsu_a;  lsu_rready = i.lsu_rr;
    m_arready   = i.m_ar;   m_rvalid   = i.m_rv;   m_rdata    = i.m_rd;
    m_rresp     = i.m_rs;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t act;
    int   cyc;
    logic exp_lsu [6] = '{Y, Y, Y, Y, N, Y};
    int   exp_strk[6] = '{1, 2, 3, 4, 0, 1};

    drive(in_t'{Y, 32'h1234_5678, Y, Y, 32'h8765_4321, Y, Y, Y, 32'hFFFF_FFFF, R3});

    // IFU-only read, slave answers two cycles into DATA
    add(in_t'{Y,32'h8000_0000,N, N,Z,N, N,N,Z,R0}, out_t'{Y,N,N,Z, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,N, N,Z,N, Y,N,Z,R0},             out_t'{N,N,Y,32'h8000_0000, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,Y, N,Z,N, N,N,Z,R0},             out_t'{N,N,N,32'h8000_0000, Y,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,Y, N,Z,N, N,N,Z,R0},             out_t'{N,N,N,32'h8000_0000, Y,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,Y, N,Z,N, N,Y,32'hDEAD_BEEF,R0}, out_t'{N,N,N,32'h8000_0000, Y,Y,32'hDEAD_BEEF,R0, N,Z,R0});
    add(in_t'{N,Z,N, N,Z,N, N,N,Z,R0},             out_t'{N,N,N,32'h8000_0000, N,N,Z,R0, N,Z,R0});
    // LSU read with DECERR, then an ordinary IFU read
    add(in_t'{N,Z,N, Y,32'hA000_0050,N, N,N,Z,R0}, out_t'{N,Y,N,32'h8000_0000, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,N, N,Z,N, Y,N,Z,R0},             out_t'{N,N,Y,32'hA000_0050, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,N, N,Z,Y, N,Y,32'h1234_5678,R3}, out_t'{N,N,N,32'hA000_0050, Y,N,Z,R0, Y,32'h1234_5678,R3});
    add(in_t'{Y,32'h8000_0004,N, N,Z,N, N,N,Z,R0}, out_t'{Y,N,N,32'hA000_0050, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,N, N,Z,N, Y,N,Z,R0},             out_t'{N,N,Y,32'h8000_0004, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,Y, N,Z,N, N,Y,32'h0000_0013,R0}, out_t'{N,N,N,32'h8000_0004, Y,Y,32'h0000_0013,R0, N,Z,R0});
    add(in_t'{N,Z,N, N,Z,N, N,N,Z,R0},             out_t'{N,N,N,32'h8000_0004, N,N,Z,R0, N,Z,R0});
    // IFU read: m_arready stalled 5 cycles, LSU waiting; then owner withholds rready 3 cycles
    add(in_t'{Y,32'h8000_0008,N, N,Z,N, N,N,Z,R0}, out_t'{Y,N,N,32'h8000_0004, N,N,Z,R0, N,Z,R0});
    for (int k = 0; k < 5; k++)
      add(in_t'{N,Z,N, Y,32'h1111_0000,N, N,N,Z,R0}, out_t'{N,N,Y,32'h8000_0008, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,N, Y,32'h1111_0000,N, Y,N,Z,R0},   out_t'{N,N,Y,32'h8000_0008, N,N,Z,R0, N,Z,R0});
    for (int k = 0; k < 3; k++)
      add(in_t'{N,Z,N, Y,32'h1111_0000,N, N,Y,32'hCAFE_F00D,R2},
          out_t'{N,N,N,32'h8000_0008, N,Y,32'hCAFE_F00D,R2, N,Z,R0});
    add(in_t'{N,Z,Y, Y,32'h1111_0000,N, N,Y,32'hCAFE_F00D,R2},
        out_t'{N,N,N,32'h8000_0008, Y,Y,32'hCAFE_F00D,R2, N,Z,R0});
    add(in_t'{N,Z,N, Y,32'h1111_0000,N, N,N,Z,R0}, out_t'{N,Y,N,32'h8000_0008, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,N, N,Z,N, Y,N,Z,R0},             out_t'{N,N,Y,32'h1111_0000, N,N,Z,R0, N,Z,R0});
    add(in_t'{N,Z,N, N,Z,Y, N,Y,Z,R0},             out_t'{N,N,N,32'h1111_0000, Y,N,Z,R0, Y,Z,R0});
    add(in_t'{N,Z,N, N,Z,N, N,N,Z,R0},             out_t'{N,N,N,32'h1111_0000, N,N,Z,R0, N,Z,R0});

    // Reset state, with both requesters and all slave-side handshakes asserted
    repeat (2) @(negedge clk);
    #1;
    check1("rst_arready", {30'd0, ifu_arready, lsu_arready}, 32'd0);
    check1("rst_m_arvalid", {31'd0, m_arvalid}, 32'd0);
    check1("rst_m_araddr", m_araddr, 32'd0);
    check1("rst_rvalid_rready", {29'd0, ifu_rvalid, lsu_rvalid, m_rready}, 32'd0);
    check1("rst_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    rst = 1'b0;
    drive(in_t'{N,Z,N, N,Z,N, N,N,Z,R0});

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      drive(vecs[r].i);
      #1;
      act = {ifu_arready, lsu_arready, m_arvalid, m_araddr, m_rready, ifu_rvalid,
             ifu_rdata, ifu_rresp, lsu_rvalid, lsu_rdata, lsu_rresp};
      n_checks++;
      if (act !== vecs[r].o) begin
        n_fail++;
        $display("FAIL row%0d: got %h expected %h", r, act, vecs[r].o);
      end
    end

    // Both requesters held continuously: LSU x4, IFU, LSU
    @(negedge clk);
    drive(in_t'{Y,32'h8000_1000,Y, Y,32'h2000_0000,Y, Y,Y,Z,R0});
    for (int k = 0; k < 6; k++) begin
      cyc = 0;
      #1;
      while (!(ifu_arready || lsu_arready) && cyc < 8) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check1($sformatf("grant%0d", k), {30'd0, ifu_arready, lsu_arready},
             exp_lsu[k] ? 32'd1 : 32'd2);
      @(posedge clk);
      #1;
      check1($sformatf("streak%0d", k), 32'(dut.u_pick.streak_q), 32'(exp_strk[k]));
      check1($sformatf("streak_addr%0d", k), m_araddr,
             exp_lsu[k] ? 32'h2000_0000 : 32'h8000_1000);
      @(negedge clk);
    end
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    drive(in_t'{N,Z,N, N,Z,N, N,N,Z,R0});
    #1;
    check1("streak_drain_idle", {30'd0, dut.state_q}, {30'd0, ST_IDLE});

    // Asynchronous reset in the middle of DATA
    @(negedge clk);
    drive(in_t'{Y,32'h8000_0010,N, N,Z,N, N,N,Z,R0});
    #1;
    check1("pre_rst_arready", {31'd0, ifu_arready}, 32'd1);
    @(negedge clk);
    drive(in_t'{N,Z,N, N,Z,N, Y,N,Z,R0});
    @(negedge clk);
    drive(in_t'{N,Z,N, N,Z,N, N,Y,32'h0000_0055,R0});
    #1;
    check1("pre_rst_rvalid", {31'd0, ifu_rvalid}, 32'd1);
    #2;
    rst = 1'b1;
    ifu_rready  = 1'b1;
    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b1;
    #1;
    check1("mid_rst_handshakes",
           {26'd0, ifu_rvalid, lsu_rvalid, m_rready, ifu_arready, lsu_arready, m_arvalid}, 32'd0);
    check1("mid_rst_rdata", ifu_rdata, 32'd0);
    check1("mid_rst_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    check1("mid_rst_streak", 32'(dut.u_pick.streak_q), 32'd0);
    check1("mid_rst_m_araddr", m_araddr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(in_t'{Y,32'h8000_0014,N, N,Z,N, N,N,Z,R0});
    #1;
    check1("post_rst_arready", {30'd0, ifu_arready, lsu_arready}, 32'd2);
    @(negedge clk);
    drive(in_t'{N,Z,N, N,Z,N, Y,N,Z,R0});
    #1;
    check1("post_rst_m_arvalid", {31'd0, m_arvalid}, 32'd1);
    check1("post_rst_m_araddr", m_araddr, 32'h8000_0014);
    @(negedge clk);
    drive(in_t'{N,Z,Y, N,Z,N, N,Y,32'h0BAD_F00D,R0});
    #1;
    check1("post_rst_rvalid", {30'd0, ifu_rvalid, m_rready}, 32'd3);
    check1("post_rst_rdata", ifu_rdata, 32'h0BAD_F00D);
    @(negedge clk);
    drive(in_t'{N,Z,N, N,Z,N, N,N,Z,R0});
    #1;
    check1("post_rst_idle", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
